// File: rtl/mem_port_arbiter.sv
// Arbiter that lets data access (D), instruction fetch (I) and a loader port (L) share one
// single-port synchronous memory. D has priority over I unless I has been starved; L gets the memory only in lock mode.
module mem_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_d_req,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [DATA_W-1:0] w_d_wdata,
    input  logic              w_i_req,
    input  logic [ADDR_W-1:0] w_i_addr,
    input  logic              w_l_lock,
    input  logic              w_l_req,
    input  logic              w_l_we,
    input  logic [ADDR_W-1:0] w_l_addr,
    input  logic [DATA_W-1:0] w_l_wdata,
    output logic [2:0]        w_gnt,
    output logic              r_rvalid,
    output logic [1:0]        r_rid,
    output logic [DATA_W-1:0] w_rdata,
    output logic              r_lock_ack,
    output logic [ADDR_W-1:0] w_m_addr,
    output logic              w_m_we,
    output logic [DATA_W-1:0] w_m_wdata,
    input  logic [DATA_W-1:0] w_m_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t     state, next_state;
    logic [3:0] starve;
    logic       is_read;
    logic [1:0] read_id;

    always_comb begin
        w_gnt      = 3'b000;
        next_state = state;
        if (w_rst_n) begin
            case (state)
                RUN: begin
                    if ((starve == STARVE_LIM) && w_i_req)
                        w_gnt = 3'b010;
                    else if (w_d_req)
                        w_gnt = 3'b001;
                    else if (w_i_req)
                        w_gnt = 3'b010;
                    if (w_l_lock)
                        next_state = DRAIN;
                end
                // One idle cycle lets the final RUN read response come back before L owns the port.
                DRAIN: next_state = w_l_lock ? LOCK : RUN;
                LOCK: begin
                    if (!w_l_lock)
                        next_state = RUN;
                    else if (w_l_req)
                        w_gnt = 3'b100;
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_comb begin
        w_m_addr  = '0;
        w_m_we    = 1'b0;
        w_m_wdata = '0;
        is_read   = 1'b0;
        read_id   = 2'd0;
        case (w_gnt)
            3'b001: begin
                w_m_addr  = w_d_addr;
                w_m_we    = w_d_we;
                w_m_wdata = w_d_wdata;
                is_read   = !w_d_we;
                read_id   = 2'd0;
            end
            3'b010: begin
                w_m_addr  = w_i_addr;
                is_read   = 1'b1;
                read_id   = 2'd1;
            end
            3'b100: begin
                w_m_addr  = w_l_addr;
                w_m_we    = w_l_we;
                w_m_wdata = w_l_wdata;
                is_read   = !w_l_we;
                read_id   = 2'd2;
            end
            default: ;
        endcase
    end

    assign w_rdata = w_m_rdata;

    // The starvation count only moves while RUN arbitrates; it is frozen otherwise.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state      <= RUN;
            starve     <= 4'd0;
            r_rvalid   <= 1'b0;
            r_rid      <= 2'd0;
            r_lock_ack <= 1'b0;
        end else begin
            state      <= next_state;
            r_lock_ack <= (next_state == LOCK);
            r_rvalid   <= is_read;
            if (is_read)
                r_rid <= read_id;
            if (state == RUN) begin
                if (w_i_req && !w_gnt[1])
                    starve <= (starve == STARVE_LIM) ? starve : starve + 4'd1;
                else
                    starve <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed stimulus with literal expectations plus
// a per-cycle behavioural model of the arbitration rules and a shadow copy of memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              d_req, d_we, i_req, l_lock, l_req, l_we;
    logic [ADDR_W-1:0] d_addr, i_addr, l_addr;
    logic [DATA_W-1:0] d_wdata, l_wdata;
    logic [2:0]        gnt;
    logic              rvalid, lock_ack, m_we;
    logic [1:0]        rid;
    logic [DATA_W-1:0] rdata, m_wdata, m_rdata;
    logic [ADDR_W-1:0] m_addr;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem    [2048];
    logic [DATA_W-1:0] shadow [2048];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
        .w_i_req(i_req), .w_i_addr(i_addr),
        .w_l_lock(l_lock), .w_l_req(l_req), .w_l_we(l_we), .w_l_addr(l_addr), .w_l_wdata(l_wdata),
        .w_gnt(gnt), .r_rvalid(rvalid), .r_rid(rid), .w_rdata(rdata), .r_lock_ack(lock_ack),
        .w_m_addr(m_addr), .w_m_we(m_we), .w_m_wdata(m_wdata), .w_m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_we)
            mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    function automatic logic [DATA_W-1:0] initWord(input int a);
        return (32'(a) * 32'h0101) ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic a_rst_n, input logic a_d_req, input logic a_d_we,
        input logic [ADDR_W-1:0] a_d_addr, input logic [DATA_W-1:0] a_d_wdata,
        input logic a_i_req, input logic [ADDR_W-1:0] a_i_addr,
        input logic a_l_lock, input logic a_l_req, input logic a_l_we,
        input logic [ADDR_W-1:0] a_l_addr, input logic [DATA_W-1:0] a_l_wdata);
        @(posedge clk);
        #1;
        rst_n = a_rst_n; d_req = a_d_req; d_we = a_d_we; d_addr = a_d_addr; d_wdata = a_d_wdata;
        i_req = a_i_req; i_addr = a_i_addr;
        l_lock = a_l_lock; l_req = a_l_req; l_we = a_l_we; l_addr = a_l_addr; l_wdata = a_l_wdata;
        @(negedge clk);
    endtask

    // Behavioural model: mode 0=run, 1=drain, 2=lock; one pending read response at most.
    initial begin : model
        int mode = 0;
        int denials = 0;
        bit known = 0;
        bit exp_valid = 0;
        logic [1:0] exp_rid = 2'd0;
        logic [DATA_W-1:0] exp_rdata = '0;
        logic [2:0] e_gnt;
        logic [ADDR_W-1:0] e_addr;
        logic e_we;
        logic [DATA_W-1:0] e_wdata;
        logic s_rst_n, s_i_req, s_l_lock;
        forever begin
            @(negedge clk);
            e_gnt = 3'b000;
            if (rst_n === 1'b1) begin
                if (mode == 0) begin
                    if (i_req && (denials >= STARVE_MAX || !d_req)) e_gnt = 3'b010;
                    else if (d_req) e_gnt = 3'b001;
                end else if (mode == 2 && l_lock && l_req) begin
                    e_gnt = 3'b100;
                end
            end
            e_addr = '0; e_we = 1'b0; e_wdata = '0;
            if (e_gnt == 3'b001) begin e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; end
            if (e_gnt == 3'b010) begin e_addr = i_addr; end
            if (e_gnt == 3'b100) begin e_addr = l_addr; e_we = l_we; e_wdata = l_wdata; end
            if (known) begin
                checkOutput("model_gnt", 32'(gnt), 32'(e_gnt));
                checkOutput("model_m_we", 32'(m_we), 32'(e_we));
                checkOutput("model_m_addr", 32'(m_addr), 32'(e_addr));
                checkOutput("model_m_wdata", m_wdata, e_wdata);
                checkOutput("model_rvalid", 32'(rvalid), 32'(exp_valid));
                checkOutput("model_rid", 32'(rid), 32'(exp_rid));
                checkOutput("model_lock_ack", 32'(lock_ack), (mode == 2) ? 32'd1 : 32'd0);
                if (exp_valid)
                    checkOutput("model_rdata", rdata, exp_rdata);
            end
            s_rst_n = rst_n; s_i_req = i_req; s_l_lock = l_lock;
            @(posedge clk);
            if (s_rst_n !== 1'b1) begin
                mode = 0; denials = 0; exp_valid = 0; exp_rid = 2'd0; known = 1;
            end else begin
                exp_valid = 0;
                if (e_gnt != 3'b000 && !e_we) begin
                    exp_valid = 1;
                    exp_rid   = (e_gnt == 3'b001) ? 2'd0 : (e_gnt == 3'b010) ? 2'd1 : 2'd2;
                    exp_rdata = shadow[e_addr];
                end
                if (e_we)
                    shadow[e_addr] = e_wdata;
                if (mode == 0)
                    denials = (s_i_req && e_gnt != 3'b010) ? ((denials < STARVE_MAX) ? denials + 1 : denials) : 0;
                if (mode == 0)      mode = s_l_lock ? 1 : 0;
                else if (mode == 1) mode = s_l_lock ? 2 : 0;
                else                mode = s_l_lock ? 2 : 0;
            end
        end
    end

    initial begin : stimulus
        logic [2:0] pat [8];
        pat = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
        for (int a = 0; a < 2048; a++) begin
            mem[a]    = initWord(a);
            shadow[a] = initWord(a);
        end
        mem[5] = 32'h1234; shadow[5] = 32'h1234;
        rst_n = 0; d_req = 1; d_we = 0; d_addr = 0; d_wdata = 0; i_req = 1; i_addr = 0;
        l_lock = 0; l_req = 1; l_we = 0; l_addr = 0; l_wdata = 0;

        $display("[TB] reset with all requests high");
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("reset_gnt2", 32'(gnt), 32'd0);
        checkOutput("reset_m_we", 32'(m_we), 32'd0);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("first_gnt_d", 32'(gnt), 32'b001);

        $display("[TB] D read of address 5");
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("d_read_gnt", 32'(gnt), 32'b001);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("d_read_rvalid", 32'(rvalid), 32'd1);
        checkOutput("d_read_rid", 32'(rid), 32'd0);
        checkOutput("d_read_rdata", rdata, 32'h1234);

        $display("[TB] D and I contending");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 1, 0, 10, 0, 1, 20, 0, 0, 0, 0, 0);
            checkOutput($sformatf("starve_gnt_%0d", k), 32'(gnt), 32'(pat[k]));
        end

        $display("[TB] D write then I read of address 7");
        applyStimulus(1, 1, 1, 7, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_gnt", 32'(gnt), 32'b001);
        checkOutput("wr_m_we", 32'(m_we), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        checkOutput("wr_i_gnt", 32'(gnt), 32'b010);
        checkOutput("wr_no_rvalid", 32'(rvalid), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("i_rvalid", 32'(rvalid), 32'd1);
        checkOutput("i_rid", 32'(rid), 32'd1);
        checkOutput("i_rdata", rdata, 32'hCAFE);

        $display("[TB] lock sequence");
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("lock_run_gnt", 32'(gnt), 32'b001);
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("drain_gnt", 32'(gnt), 32'd0);
        checkOutput("drain_rvalid", 32'(rvalid), 32'd1);
        checkOutput("drain_rid", 32'(rid), 32'd0);
        checkOutput("drain_rdata", rdata, 32'h1234);
        checkOutput("drain_lock_ack", 32'(lock_ack), 32'd0);
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 1, 1, 1, 0, 32'h20);
        checkOutput("lock_ack", 32'(lock_ack), 32'd1);
        checkOutput("lock_l_gnt", 32'(gnt), 32'b100);
        checkOutput("lock_m_addr", 32'(m_addr), 32'd0);
        checkOutput("lock_m_wdata", m_wdata, 32'h20);
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("lock_l_read_gnt", 32'(gnt), 32'b100);
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("unlock_no_gnt", 32'(gnt), 32'd0);
        checkOutput("l_rid", 32'(rid), 32'd2);
        checkOutput("l_rdata", rdata, 32'h20);
        applyStimulus(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resume_gnt_d", 32'(gnt), 32'b001);
        checkOutput("resume_lock_ack", 32'(lock_ack), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resume_rdata", rdata, initWord(6));

        $display("[TB] reset right after a granted read");
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("pre_reset_gnt", 32'(gnt), 32'b001);
        applyStimulus(0, 1, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("in_reset_gnt", 32'(gnt), 32'd0);
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("post_reset_lock_ack", 32'(lock_ack), 32'd0);
        checkOutput("post_reset_gnt_d", 32'(gnt), 32'b001);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_rdata", rdata, 32'h1234);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
